conv_window_coord_gen: RTL

CONV_WINDOW_COORD_GEN -- requirements
Module: conv_window_coord_gen

---
 rtl/conv_pkg.sv | 18 +
 rtl/win_axis_cnt.sv | 24 ++
 rtl/conv_window_coord_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: FSM state encoding and default geometry shared by the window
// generator and the downstream address-map stage.
package conv_pkg;

    localparam int CONV_KERNEL     = 5;
    localparam int CONV_ADDR_WIDTH = 32;
    localparam int CONV_IMG_H      = 28;
    localparam int CONV_IMG_W      = 28;
    localparam int CONV_STRIDE     = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} conv_state_t;

    // Largest stride-aligned origin whose kernel still fits inside the axis.
    function automatic int axis_last(input int img, input int kernel, input int stride);
        return ((img - kernel) / stride) * stride;
    endfunction

endpackage

// File: rtl/win_axis_cnt.sv
// win_axis_cnt: one axis of the window origin; steps by STEP and wraps to 0
// after reaching LIMIT.
module win_axis_cnt #(
    parameter int LIMIT = 0,
    parameter int STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value,
    output logic        at_last
);

    assign at_last = value == 16'(LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr)
            value <= '0;
        else if (inc)
            value <= at_last ? '0 : value + 16'(STEP);
    end

endmodule

// File: rtl/conv_window_coord_gen.sv
// conv_window_coord_gen: raster-scans KERNELxKERNEL windows over a feature map
// and emits every lane's (x,y); CONV_COORD_STALL_CNT_EN adds a stall counter.
module conv_window_coord_gen
    import conv_pkg::*;
#(
    parameter int KERNEL     = CONV_KERNEL,
    parameter int ADDR_WIDTH = CONV_ADDR_WIDTH,
    parameter int IMG_H      = CONV_IMG_H,
    parameter int IMG_W      = CONV_IMG_W,
    parameter int STRIDE     = CONV_STRIDE,
    parameter int PORT_NUM   = KERNEL * KERNEL
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PORT_NUM*ADDR_WIDTH-1:0] x,
    output logic [PORT_NUM*ADDR_WIDTH-1:0] y,
    output logic [15:0]                    win_row,
    output logic [15:0]                    win_col,
    output logic                           last,
    output logic                           done
`ifdef CONV_COORD_STALL_CNT_EN
    ,
    output logic [15:0]                    stall_cnt
`endif
);

    localparam int ROW_LAST = axis_last(IMG_H, KERNEL, STRIDE);
    localparam int COL_LAST = axis_last(IMG_W, KERNEL, STRIDE);

    conv_state_t state, state_nxt;
    logic accept, hs, row_last, col_last;

    assign accept = state == IDLE && start;
    assign hs     = out_valid && out_ready;
    assign last   = out_valid && row_last && col_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= state_nxt == RUN;
            busy      <= state_nxt != IDLE;
            done      <= state_nxt == DONE;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = RUN;
        else if (state == RUN && hs && row_last && col_last)
            state_nxt = DONE;
        else if (state == DONE)
            state_nxt = IDLE;
    end

    win_axis_cnt #(.LIMIT(COL_LAST), .STEP(STRIDE)) u_col (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .inc     (hs),
        .value   (win_col),
        .at_last (col_last)
    );

    win_axis_cnt #(.LIMIT(ROW_LAST), .STEP(STRIDE)) u_row (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .inc     (hs && col_last),
        .value   (win_row),
        .at_last (row_last)
    );

    // Lanes are offsets of the registered origin, zeroed whenever no window is presented.
    for (genvar r = 0; r < KERNEL; r++) begin : g_row
        for (genvar c = 0; c < KERNEL; c++) begin : g_col
            localparam int LANE = r * KERNEL + c;
            assign x[LANE*ADDR_WIDTH +: ADDR_WIDTH] = out_valid ? ADDR_WIDTH'(win_row) + ADDR_WIDTH'(r) : '0;
            assign y[LANE*ADDR_WIDTH +: ADDR_WIDTH] = out_valid ? ADDR_WIDTH'(win_col) + ADDR_WIDTH'(c) : '0;
        end
    end

`ifdef CONV_COORD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || accept)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
